// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues I-cache reads and presents
// each returned instruction (with PC and PC+4) to IF/ID over a valid/hold
// handshake. Redirects arriving during an outstanding miss are parked until
// the in-flight access completes.
//
//  state | meaning
//  FETCH | request at pc; hit data passes straight through to IF/ID
//  HOLD  | hit was stalled; replay registered pc/instruction, no cache request
//  DRAIN | redirect seen during a miss; wait out the old access, then jump
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_jump_signal,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_readdata,
    input  logic        imem_busywait,
    output logic [31:0] pc_out,
    output logic [31:0] pc_4_out,
    output logic [31:0] instruction_out,
    output logic        fetch_busywait
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] hold_pc, hold_pc_next;
    logic [31:0] hold_inst, hold_inst_next;
    logic [31:0] pending_target, pending_target_next;
    logic [31:0] target_aligned;

    assign target_aligned = {branch_target[31:2], 2'b00};

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= FETCH;
            pc             <= {RESET_PC[31:2], 2'b00};
            hold_pc        <= 32'd0;
            hold_inst      <= 32'd0;
            pending_target <= 32'd0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            hold_pc        <= hold_pc_next;
            hold_inst      <= hold_inst_next;
            pending_target <= pending_target_next;
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_next          = state;
        pc_next             = pc;
        hold_pc_next        = hold_pc;
        hold_inst_next      = hold_inst;
        pending_target_next = pending_target;
        case (state)
            FETCH: begin
                if (branch_jump_signal) begin
                    if (imem_busywait) begin
                        pending_target_next = target_aligned;
                        state_next          = DRAIN;
                    end else begin
                        pc_next = target_aligned;
                    end
                end else if (!imem_busywait) begin
                    if (stall) begin
                        hold_pc_next   = pc;
                        hold_inst_next = imem_readdata;
                        state_next     = HOLD;
                    end else begin
                        pc_next = pc + 32'd4;
                    end
                end
            end
            HOLD: begin
                if (branch_jump_signal) begin
                    pc_next    = target_aligned;
                    state_next = FETCH;
                end else if (!stall) begin
                    pc_next    = hold_pc + 32'd4;
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                if (!imem_busywait) begin
                    pc_next    = branch_jump_signal ? target_aligned : pending_target;
                    state_next = FETCH;
                end else if (branch_jump_signal) begin
                    pending_target_next = target_aligned;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Cache request and IF/ID presentation; FETCH passes hit data through.
    always_comb begin
        imem_read       = 1'b1;
        imem_address    = pc;
        pc_out          = pc;
        instruction_out = imem_readdata;
        fetch_busywait  = 1'b1;
        case (state)
            FETCH: fetch_busywait = imem_busywait;
            HOLD: begin
                imem_read       = 1'b0;
                pc_out          = hold_pc;
                instruction_out = hold_inst;
                fetch_busywait  = 1'b0;
            end
            default: fetch_busywait = 1'b1;
        endcase
        if (branch_jump_signal) begin
            fetch_busywait = 1'b1;
        end
        if (reset) begin
            imem_read      = 1'b0;
            fetch_busywait = 1'b1;
        end
    end

    assign pc_4_out = pc_out + 32'd4;

endmodule
